// File: rtl/axi_byte_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_byte_pkg
// Description : Shared response codes, size encoding and FSM state types for
//               the byte-wide AXI-style responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_byte_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'b000;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  // A bad size outranks a decode miss.
  function automatic logic [1:0] resp_of(input logic [2:0] size, input logic hit);
    if (size != SIZE_BYTE) return RESP_SLVERR;
    if (!hit)              return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi_byte_ram
// Description : Single-clock byte RAM, one write port, one registered read
//               port with synchronous clear of the read register.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_byte_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic             rclr,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read landing on the same edge as a write to that byte sees the old value.
  always_ff @(posedge clk) begin
    if (rclr)    rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/axi_byte_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_byte_responder
// Description : AXI-style byte-wide memory target with independent read and
//               write channels. Define AXI_RESP_STALL_EN to add LFSR-driven
//               pseudo-random stalls on arready/awready/wready.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_byte_responder
  import axi_byte_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              MEM_DEPTH    = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int              READ_LATENCY = 2,
  parameter logic [15:0]     STALL_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arsize,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [7:0]        s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awsize,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [7:0]        s_axi_wdata,
  input  logic [0:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready
);

  localparam int                IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [3:0]        LAT_INIT  = 4'(READ_LATENCY);

  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, off} < DEPTH_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr - BASE_ADDR);
  endfunction

  // ready_gate[0/1/2] qualify arready/awready/wready.
  logic [2:0] ready_gate;

`ifdef AXI_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (areset) lfsr <= STALL_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign ready_gate = lfsr[2:0];
`else
  // Seed is meaningless without the LFSR; OR-ing it in keeps the gate all-ones.
  assign ready_gate = 3'b111 | STALL_SEED[2:0];
`endif

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  rd_state_t         rd_state, rd_state_nx;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_nx;
  logic [2:0]        ar_size_q, ar_size_nx;
  logic [3:0]        rd_cnt_q, rd_cnt_nx;
  logic              arready_q, arready_nx;
  logic              rvalid_q, rvalid_nx;
  logic [1:0]        rresp_q, rresp_nx;
  logic              rd_sample;
  logic              ar_hs;

  assign s_axi_arready = arready_q & ready_gate[0];
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  always_ff @(posedge clk) begin
    if (areset) begin
      rd_state  <= RD_IDLE;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      rd_cnt_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rd_state  <= rd_state_nx;
      ar_addr_q <= ar_addr_nx;
      ar_size_q <= ar_size_nx;
      rd_cnt_q  <= rd_cnt_nx;
      arready_q <= arready_nx;
      rvalid_q  <= rvalid_nx;
      rresp_q   <= rresp_nx;
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    ar_addr_nx  = ar_addr_q;
    ar_size_nx  = ar_size_q;
    rd_cnt_nx   = rd_cnt_q;
    arready_nx  = arready_q;
    rvalid_nx   = rvalid_q;
    rresp_nx    = rresp_q;
    rd_sample   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready_nx = 1'b1;
        if (ar_hs) begin
          arready_nx  = 1'b0;
          ar_addr_nx  = s_axi_araddr;
          ar_size_nx  = s_axi_arsize;
          rd_cnt_nx   = LAT_INIT;
          rd_state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rd_sample   = 1'b1;
          rvalid_nx   = 1'b1;
          rresp_nx    = resp_of(ar_size_q, addr_hit(ar_addr_q));
          rd_state_nx = RD_RESP;
        end else begin
          rd_cnt_nx = rd_cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          rvalid_nx   = 1'b0;
          arready_nx  = 1'b1;
          rd_state_nx = RD_IDLE;
        end
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;

  // --------------------------------------------------------------------------
  // Write channel
  // --------------------------------------------------------------------------
  wr_state_t         wr_state, wr_state_nx;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_nx;
  logic [2:0]        aw_size_q, aw_size_nx;
  logic [7:0]        wdata_q, wdata_nx;
  logic              wstrb_q, wstrb_nx;
  logic              aw_held, aw_held_nx;
  logic              w_held, w_held_nx;
  logic              awready_q, awready_nx;
  logic              wready_q, wready_nx;
  logic              bvalid_q, bvalid_nx;
  logic [1:0]        bresp_q, bresp_nx;
  logic [1:0]        wr_resp;
  logic              wr_commit;
  logic              aw_hs, w_hs;

  assign s_axi_awready = awready_q & ready_gate[1];
  assign s_axi_wready  = wready_q  & ready_gate[2];
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid  & s_axi_wready;
  assign wr_resp       = resp_of(aw_size_q, addr_hit(aw_addr_q));

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_state  <= WR_IDLE;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wr_state  <= wr_state_nx;
      aw_addr_q <= aw_addr_nx;
      aw_size_q <= aw_size_nx;
      wdata_q   <= wdata_nx;
      wstrb_q   <= wstrb_nx;
      aw_held   <= aw_held_nx;
      w_held    <= w_held_nx;
      awready_q <= awready_nx;
      wready_q  <= wready_nx;
      bvalid_q  <= bvalid_nx;
      bresp_q   <= bresp_nx;
    end
  end

  always_comb begin
    wr_state_nx = wr_state;
    aw_addr_nx  = aw_addr_q;
    aw_size_nx  = aw_size_q;
    wdata_nx    = wdata_q;
    wstrb_nx    = wstrb_q;
    aw_held_nx  = aw_held;
    w_held_nx   = w_held;
    awready_nx  = awready_q;
    wready_nx   = wready_q;
    bvalid_nx   = bvalid_q;
    bresp_nx    = bresp_q;
    wr_commit   = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready_nx = ~aw_held;
        wready_nx  = ~w_held;
        if (aw_hs) begin
          aw_held_nx = 1'b1;
          awready_nx = 1'b0;
          aw_addr_nx = s_axi_awaddr;
          aw_size_nx = s_axi_awsize;
        end
        if (w_hs) begin
          w_held_nx = 1'b1;
          wready_nx = 1'b0;
          wdata_nx  = s_axi_wdata;
          wstrb_nx  = s_axi_wstrb[0];
        end
        // Commit one edge after the later of the two payloads was captured.
        if (aw_held && w_held) begin
          wr_commit   = (wr_resp == RESP_OKAY) && wstrb_q;
          aw_held_nx  = 1'b0;
          w_held_nx   = 1'b0;
          awready_nx  = 1'b0;
          wready_nx   = 1'b0;
          bvalid_nx   = 1'b1;
          bresp_nx    = wr_resp;
          wr_state_nx = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          bvalid_nx   = 1'b0;
          awready_nx  = 1'b1;
          wready_nx   = 1'b1;
          wr_state_nx = WR_IDLE;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;

  // --------------------------------------------------------------------------
  // Backing store; the read register doubles as the rdata output register.
  // --------------------------------------------------------------------------
  axi_byte_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_commit & ~areset),
    .waddr (addr_idx(aw_addr_q)),
    .wdata (wdata_q),
    .re    (rd_sample),
    .rclr  (areset | (rd_sample & (rresp_nx != RESP_OKAY))),
    .raddr (addr_idx(ar_addr_q)),
    .rdata (s_axi_rdata)
  );

endmodule
`default_nettype wire
